keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001: Parameter SCAN_DIV, default 50000, clk cycles each column is driven while scanning.
REQ-002: Parameter DEBOUNCE_CYCLES, default 250000, stable cycles required for press and release acceptance.
REQ-003: Parameter REPEAT_CYCLES, default 5000000, auto-repeat interval (used only with KEYPAD_REPEAT_EN).
REQ-004: clk  input  1  single system clock; all state on rising edge.
REQ-005: reset  input  1  asynchronous, active-low reset.
REQ-006: row  input  4  keypad row sense, active-high (1 = key in driven column pressed), asynchronous to clk.
REQ-007: col  output  4  one-hot active-high column drive.
REQ-008: key_code  output  4  hex value of last accepted key.
REQ-009: key_valid  output  1  single-cycle pulse per accepted key.
REQ-010: digit_new  output  4  most recent accepted key, for dual seven-segment display.
REQ-011: digit_old  output  4  key accepted before digit_new.

Function
REQ-012: row SHALL pass through a two-flop synchronizer; all decisions use synchronized row (rows_s).
REQ-013: States SHALL be SCAN, DEBOUNCE, EMIT, HOLD, RELEASE.
REQ-014: SCAN: col rotates 0001->0010->0100->1000->0001, advancing every SCAN_DIV cycles; rows_s sampled only once scan counter >= 2 (synchronizer latency).
REQ-015: SCAN->DEBOUNCE when sampled rows_s != 0; col frozen; captured row = lowest-index set bit of rows_s.
REQ-016: DEBOUNCE: counter increments while captured row bit is 1; if it reads 0, return to SCAN with col advanced one position, counter cleared.
REQ-017: DEBOUNCE->EMIT when counter reaches DEBOUNCE_CYCLES-1.
REQ-018: EMIT lasts exactly one cycle: key_valid=1, key_code=decoded key, digit_old<=digit_new, digit_new<=decoded key, all in that same cycle; then HOLD.
REQ-019: Decode (row r, col c): r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: E,0,F,D.
REQ-020: HOLD: col frozen; remain while captured row bit is 1; go RELEASE when it reads 0; other row bits ignored (no second key).
REQ-021: RELEASE: counter increments while captured row bit is 0, clears to 0 if it reads 1; when counter reaches DEBOUNCE_CYCLES-1, go SCAN with col advanced one position.
REQ-022: key_valid SHALL be 0 in every state except EMIT (and repeat cycles, REQ-026).
REQ-023: All counters saturate-free and clear on every state transition; width = clog2 of the largest parameter.

Reset
REQ-024: On reset low, immediately: state SCAN, col=0001, key_code=0, key_valid=0, digit_new=0, digit_old=0, counters and synchronizer cleared; reset in any state (incl. mid-DEBOUNCE/EMIT) SHALL produce no key_valid.
REQ-025: After reset release, the first column advance SHALL occur SCAN_DIV cycles later.

Configuration
REQ-026: KEYPAD_REPEAT_EN defined: in HOLD, after REPEAT_CYCLES continuous cycles, key_valid pulses one cycle with same key_code and digit shift per REQ-018, repeating every REPEAT_CYCLES while held; undefined: exactly one key_valid per press, no REPEAT_CYCLES counter logic.

Verification (SCAN_DIV=4, DEBOUNCE_CYCLES=8, REPEAT_CYCLES=16; bench models keypad: row bit driven only while col matches pressed key)
REQ-027: Reset low 3 cycles, release, no press -> col=0001, all outputs 0; col=0010 exactly 4 cycles later, wraps to 0001 after 1000.
REQ-028: Press r0/c1 held 40 cycles -> exactly one key_valid, key_code=2, digit_new=2, digit_old=0; col frozen at 0010 through HOLD.
REQ-029: Press r1/c1 with row toggling every 3 cycles for 30 cycles then stable -> no key_valid during bounce, exactly one pulse after, key_code=5.
REQ-030: Key 5 then release then key r3/c2 -> digit_old=5, digit_new=F; scanning resumes 8 cycles after each release.
REQ-031: Reset low during DEBOUNCE of key 9 -> col=0001 immediately, no key_valid, digits stay 0.
REQ-032: KEYPAD_REPEAT_EN defined, key 1 held 60 cycles -> key_valid at EMIT plus repeats at 16-cycle spacing (3 repeats); undefined -> one pulse.

Source files
------------

// File: rtl/keypad_scanner.sv
// Purpose: 4x4 matrix keypad scanner; rotates column drive, debounces press/release, decodes hex, keeps two-digit history.
// Latency: 2-cycle row synchronizer, then DEBOUNCE_CYCLES stable cycles before the one-cycle key_valid pulse.
// Backpressure: none; key_valid is a single-cycle pulse the consumer must sample every cycle.
// Optional feature: define KEYPAD_REPEAT_EN to re-pulse key_valid every REPEAT_CYCLES while a key stays held.
module keypad_scanner #(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old
);

  localparam int MAX_AB = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int MAX_P  = (MAX_AB > REPEAT_CYCLES) ? MAX_AB : REPEAT_CYCLES;
  localparam int CW     = ($clog2(MAX_P) > 2) ? $clog2(MAX_P) : 2;

  localparam logic [CW-1:0] SCAN_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] SCAN_SAMPLE = CW'(2);
  localparam logic [CW-1:0] DB_LAST     = CW'(DEBOUNCE_CYCLES - 1);
`ifdef KEYPAD_REPEAT_EN
  // Repeat pulse is registered, so fire one cycle before the period wraps.
  localparam logic [CW-1:0] REP_FIRE    = CW'(REPEAT_CYCLES - 2);
  localparam logic [CW-1:0] REP_LAST    = CW'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {SCAN, DEBOUNCE, EMIT, HOLD, RELEASE} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [3:0]    col_d;
  logic [1:0]    cap, cap_d;
  logic [3:0]    rows_meta, rows_s;
  logic          cap_bit;
  logic          emit_d;
  logic [1:0]    col_idx;
  logic [1:0]    low_row;
  logic [3:0]    dec;

  function automatic logic [3:0] decode(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'b00_00: k = 4'h1;  4'b00_01: k = 4'h2;  4'b00_10: k = 4'h3;  4'b00_11: k = 4'hA;
      4'b01_00: k = 4'h4;  4'b01_01: k = 4'h5;  4'b01_10: k = 4'h6;  4'b01_11: k = 4'hB;
      4'b10_00: k = 4'h7;  4'b10_01: k = 4'h8;  4'b10_10: k = 4'h9;  4'b10_11: k = 4'hC;
      default:  k = (c == 2'd0) ? 4'hE : (c == 2'd1) ? 4'h0 : (c == 2'd2) ? 4'hF : 4'hD;
    endcase
    return k;
  endfunction

  // Two-flop synchronizer for the asynchronous row inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rows_meta <= 4'b0000;
      rows_s    <= 4'b0000;
    end else begin
      rows_meta <= row;
      rows_s    <= rows_meta;
    end
  end

  // Helpers: captured row level, column index, lowest pressed row, decoded key.
  always_comb begin
    cap_bit = rows_s[cap];
    col_idx = col[1] ? 2'd1 : col[2] ? 2'd2 : col[3] ? 2'd3 : 2'd0;
    low_row = rows_s[0] ? 2'd0 : rows_s[1] ? 2'd1 : rows_s[2] ? 2'd2 : 2'd3;
    dec     = decode(cap, col_idx);
  end

  // Scanner state register, shared counter, column drive and captured row.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= SCAN;
      cnt   <= '0;
      col   <= 4'b0001;
      cap   <= 2'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      col   <= col_d;
      cap   <= cap_d;
    end
  end

  // Next-state logic; the counter clears on every state change.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    col_d   = col;
    cap_d   = cap;
    emit_d  = 1'b0;
    case (state)
      SCAN: begin
        if (cnt >= SCAN_SAMPLE && rows_s != 4'b0000) begin
          state_d = DEBOUNCE;
          cnt_d   = '0;
          cap_d   = low_row;
        end else if (cnt == SCAN_LAST) begin
          cnt_d = '0;
          col_d = {col[2:0], col[3]};
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      DEBOUNCE: begin
        if (!cap_bit) begin
          state_d = SCAN;
          cnt_d   = '0;
          col_d   = {col[2:0], col[3]};
        end else if (cnt == DB_LAST) begin
          state_d = EMIT;
          cnt_d   = '0;
          emit_d  = 1'b1;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      EMIT: begin
        state_d = HOLD;
        cnt_d   = '0;
      end
      HOLD: begin
        if (!cap_bit) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end
`ifdef KEYPAD_REPEAT_EN
        else begin
          cnt_d  = (cnt == REP_LAST) ? '0 : cnt + CW'(1);
          emit_d = (cnt == REP_FIRE);
        end
`endif
      end
      RELEASE: begin
        if (cap_bit) begin
          cnt_d = '0;
        end else if (cnt == DB_LAST) begin
          state_d = SCAN;
          cnt_d   = '0;
          col_d   = {col[2:0], col[3]};
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: begin
        state_d = SCAN;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs load on the edge entering the pulse cycle so code, digits and key_valid appear together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      digit_new <= 4'h0;
      digit_old <= 4'h0;
    end else begin
      key_valid <= emit_d;
      if (emit_d) begin
        key_code  <= dec;
        digit_new <= dec;
        digit_old <= digit_new;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Purpose: self-checking bench for keypad_scanner with a physical keypad model and a key-code scoreboard.
// Latency: expected keys are queued at press time and consumed whenever key_valid is seen.
// Backpressure: none; the monitor samples every falling edge.
module tb_keypad_scanner;
  localparam int SD = 4;
  localparam int DB = 8;
  localparam int RP = 16;
`ifdef KEYPAD_REPEAT_EN
  localparam int EXP_HOLD = -1;
  localparam int EXP_LONG = 4;
`else
  localparam int EXP_HOLD = 1;
  localparam int EXP_LONG = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic [3:0] digit_new;
  logic [3:0] digit_old;

  logic       key_down = 1'b0;
  logic [1:0] key_r = 2'd0;
  logic [1:0] key_c = 2'd0;

  int n_checks = 0;
  int n_fail = 0;
  int total_pulses = 0;
  int cyc = 0;
  logic [3:0] exp_q[$];
  logic [3:0] md_new = 4'h0;
  logic [3:0] md_old = 4'h0;
`ifdef KEYPAD_REPEAT_EN
  logic [3:0] last_code = 4'h0;
  bit         last_valid = 1'b0;
  int         last_pulse_cyc = 0;
`endif

  logic [3:0] keymap [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                                '{4'h4, 4'h5, 4'h6, 4'hB},
                                '{4'h7, 4'h8, 4'h9, 4'hC},
                                '{4'hE, 4'h0, 4'hF, 4'hD}};

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(RP)) dut (
    .clk(clk), .reset(reset), .row(row), .col(col), .key_code(key_code),
    .key_valid(key_valid), .digit_new(digit_new), .digit_old(digit_old)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Keypad: the pressed key's row line follows only while its column is driven.
  always_comb row = (key_down && col == (4'b0001 << key_c)) ? (4'b0001 << key_r) : 4'b0000;

  function automatic logic [3:0] onehot(input int i);
    return 4'b0001 << (i % 4);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("key_valid_in_reset", key_valid, 0);
        md_new = 4'h0;
        md_old = 4'h0;
`ifdef KEYPAD_REPEAT_EN
        last_valid = 1'b0;
`endif
      end else if (key_valid) begin
        total_pulses++;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          md_old = md_new;
          md_new = e;
          chk("key_code", key_code, e);
          chk("digit_new", digit_new, md_new);
          chk("digit_old", digit_old, md_old);
`ifdef KEYPAD_REPEAT_EN
          last_code = e;
          last_valid = 1'b1;
          last_pulse_cyc = cyc;
`endif
        end
`ifdef KEYPAD_REPEAT_EN
        else if (last_valid) begin
          chk("repeat_spacing", cyc - last_pulse_cyc, RP);
          md_old = md_new;
          md_new = last_code;
          chk("repeat_key_code", key_code, last_code);
          chk("repeat_digit_new", digit_new, md_new);
          chk("repeat_digit_old", digit_old, md_old);
          last_pulse_cyc = cyc;
        end
`endif
        else begin
          chk("unexpected_key_valid", key_valid, 0);
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    key_down = 1'b0;
    #1;
    chk("reset_col", col, 4'b0001);
    chk("reset_key_valid", key_valid, 0);
    chk("reset_key_code", key_code, 0);
    chk("reset_digit_new", digit_new, 0);
    chk("reset_digit_old", digit_old, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  // One press: optional bounce, stable hold, clean release; checks column freeze and scan resume.
  task automatic press(input int r, input int c, input int bounce, input int per,
                       input int hold, input int exp_p);
    int p0;
    exp_q.push_back(keymap[r][c]);
    p0 = total_pulses;
    key_r = 2'(r);
    key_c = 2'(c);
    key_down = 1'b1;
    for (int i = 1; i <= bounce; i++) begin
      @(negedge clk);
      if (i % per == 0) key_down = ~key_down;
    end
    key_down = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      if (total_pulses != p0) chk("col_frozen_hold", col, onehot(c));
    end
    @(negedge clk);
    key_down = 1'b0;
    // 2 sync edges + 1 edge to leave HOLD + DB release cycles.
    for (int e = 1; e <= DB + 3; e++) begin
      @(posedge clk);
      #1;
      if (e < DB + 3) chk("col_frozen_release", col, onehot(c));
      else            chk("col_resume_scan", col, onehot(c + 1));
    end
    if (exp_p >= 0) chk("pulse_count", total_pulses - p0, exp_p);
    else            chk("pulse_seen", (total_pulses - p0) >= 1, 1);
    repeat ($urandom_range(2, 8)) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got time limit reached, expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, c, b, p, h;
    fork
      monitor();
    join_none

    // Idle scanning after reset: column advances every SD cycles and wraps.
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      chk("scan_col", col, onehot(k / SD));
      chk("idle_key_valid", key_valid, 0);
    end

    // Reset in the middle of debouncing key 9: no pulse, digits stay zero.
    do_reset();
    key_r = 2'd2;
    key_c = 2'd2;
    key_down = 1'b1;
    repeat (14) @(posedge clk);
    #1;
    chk("col_frozen_debounce", col, 4'b0100);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midreset_col", col, 4'b0001);
    chk("midreset_key_valid", key_valid, 0);
    chk("midreset_digit_new", digit_new, 0);
    key_down = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("after_midreset_digit_new", digit_new, 0);
    chk("after_midreset_digit_old", digit_old, 0);

    // Directed presses: key 2 clean, key 5 bouncing, key F.
    press(0, 1, 0, 1, 40, EXP_HOLD);
    press(1, 1, 30, 3, 40, EXP_HOLD);
    press(3, 2, 0, 1, 40, EXP_HOLD);

    // Key 1 held 60 cycles straight after reset (auto-repeat timing when enabled).
    do_reset();
    press(0, 0, 0, 1, 60, EXP_LONG);

    // Random presses with random bounce; bounce "on" spans stay shorter than DB.
    for (int n = 0; n < 12; n++) begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      b = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(5, 25);
      p = $urandom_range(1, 5);
      h = $urandom_range(35, 50);
      press(r, c, b, p, h, EXP_HOLD);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
